// File: rtl/thermo_decode_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// thermo_decode_arbiter_pkg
//   Shared definitions for the thermometer decode arbiter:
//     - FSM state encoding (IDLE / SCAN / DONE)
//     - default geometry: K (code width), W (thermometer width),
//       N (requesters), IDW (requester-ID width)
// -----------------------------------------------------------------------------
package thermo_decode_arbiter_pkg;

    localparam int DEF_K   = 3;
    localparam int DEF_W   = 7;
    localparam int DEF_N   = 4;
    localparam int DEF_IDW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : thermo_decode_arbiter_pkg

// File: rtl/thermo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// thermo_rr_arbiter
//   Combinational round-robin arbiter. The search starts at requester `ptr`
//   and wraps upward modulo N; the first asserted request wins.
//
//   Ports:
//     req_valid [N]   per-requester request
//     ptr       [IDW] requester with highest priority this cycle
//     grant     [N]   one-hot grant, all zero when nobody requests
//     grant_id  [IDW] index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module thermo_rr_arbiter
    import thermo_decode_arbiter_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = DEF_IDW
) (
    input  logic [N-1:0]   req_valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the loop can leave one unassigned and infer a latch.
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDW'((int'(ptr) + i) % N);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = cand;
            end
        end
    end

endmodule : thermo_rr_arbiter

// File: rtl/thermo_decode_arbiter.sv
// -----------------------------------------------------------------------------
// thermo_decode_arbiter
//   One shared, iterative thermometer-to-binary decoder serving N requesters.
//   A round-robin arbiter grants one requester, its W-bit word is captured,
//   and the word is scanned MSB-down one bit per clock. The result is the
//   position of the highest set bit plus one (0..W), tagged with the
//   requester ID and a bubble-error flag.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid [N]         per-requester word valid
//     req_data  [N*W]       requester i word at [i*W +: W]
//     req_ready [N]         one-hot grant; a handshake is valid&&ready
//     out_valid             result valid (held until out_ready)
//     out_ready             downstream accept
//     out_code  [K]         decoded count
//     out_id    [IDW]       requester index of the result
//     out_err               word was not a legal thermometer code
// -----------------------------------------------------------------------------
module thermo_decode_arbiter
    import thermo_decode_arbiter_pkg::*;
#(
    parameter int K   = DEF_K,
    parameter int W   = DEF_W,
    parameter int N   = DEF_N,
    parameter int IDW = DEF_IDW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K-1:0]   out_code,
    output logic [IDW-1:0] out_id,
    output logic           out_err
);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [K-1:0]   idx;
    logic [W-1:0]   data;

    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   grant_word;

    logic [W:0]     pow2;
    logic [W-1:0]   legal_mask;
    logic           top_hit;
    logic           scan_stop;

    thermo_rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    // Grant is only visible in IDLE and never while reset is asserted, so a
    // requester cannot see a handshake that the FSM will not honour.
    assign req_ready  = (state == ST_IDLE && rst_n) ? grant : '0;
    assign grant_word = req_data[grant_id*W +: W];
    assign out_valid  = (state == ST_DONE);

    // pow2 = 2^idx. Bit idx-1 of the word is tested via pow2[W:1], which is
    // all zero when idx==0 and so never reads below bit 0. The legal
    // thermometer word for a given idx is 2^idx - 1.
    always_comb begin
        pow2       = '0;
        pow2[idx]  = 1'b1;
        legal_mask = W'(pow2 - (W+1)'(1));
        top_hit    = |(data & pow2[W:1]);
        scan_stop  = (idx == '0) || top_hit;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (|req_valid) state_nxt = ST_SCAN;
            ST_SCAN: if (scan_stop)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready)  state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            id       <= '0;
            idx      <= '0;
            data     <= '0;
            out_code <= '0;
            out_id   <= '0;
            out_err  <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        data <= grant_word;
                        id   <= grant_id;
                        idx  <= K'(W);
                    end
                end
                ST_SCAN: begin
                    if (scan_stop) begin
                        out_code <= idx;
                        out_id   <= id;
                        out_err  <= (data != legal_mask);
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Rotation advances only when a result is consumed.
                    if (out_ready) begin
                        ptr <= (id == IDW'(N-1)) ? '0 : id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : thermo_decode_arbiter

// File: tb/tb_thermo_decode_arbiter.sv
module tb_thermo_decode_arbiter;

    localparam int K   = 3;
    localparam int W   = 7;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [K-1:0]   out_code;
    logic [IDW-1:0] out_id;
    logic           out_err;

    int errors = 0;
    int checks = 0;

    thermo_decode_arbiter #(.K(K), .W(W), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_id    (out_id),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         rid;
        logic [6:0] word;
        int         code;
        int         err;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    // One isolated transaction: request, handshake, measure latency, check
    // the result, then accept it and confirm out_valid drops.
    task automatic run_txn(input vec_t v);
        int lat;
        @(negedge clk);
        req_valid = '0;
        req_data  = '0;
        req_valid[v.rid] = 1'b1;
        req_data[v.rid*W +: W] = v.word;
        #1;
        check($sformatf("grant r%0d", v.rid), req_ready, 32'(1 << v.rid));
        @(posedge clk);
        #1;
        req_valid = '0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency %b", v.word), lat, v.lat);
        check($sformatf("code %b", v.word), out_code, v.code);
        check($sformatf("err %b", v.word), out_err, v.err);
        check($sformatf("id %b", v.word), out_id, v.rid);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("release %b", v.word), out_valid, 0);
    endtask

    initial begin
        int n;
        int exp_ids[5];
        logic bad;

        // rid, word, code, err, latency (= W - code + 1)
        vecs[0] = '{0, 7'b0000111, 3, 0, 5};
        vecs[1] = '{1, 7'b1111111, 7, 0, 1};
        vecs[2] = '{2, 7'b0000000, 0, 0, 8};
        vecs[3] = '{3, 7'b0010110, 5, 1, 3};
        vecs[4] = '{0, 7'b0000001, 1, 0, 7};
        vecs[5] = '{1, 7'b1000000, 7, 1, 1};
        vecs[6] = '{2, 7'b0111111, 6, 0, 2};
        vecs[7] = '{3, 7'b0101010, 6, 1, 2};
        exp_ids = '{0, 1, 2, 3, 0};

        // Reset state with every requester asserting.
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        out_ready = 1'b0;
        #23;
        check("rst req_ready", req_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_code", out_code, 0);
        check("rst out_id", out_id, 0);
        check("rst out_err", out_err, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Fairness: all four requesting, out_ready held high. ptr is 0 here.
        @(negedge clk);
        req_valid = '1;
        req_data  = {N{7'b1111111}};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check($sformatf("fair grant %0d", k), req_ready, 32'(1 << exp_ids[k]));
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check($sformatf("fair id %0d", k), out_id, exp_ids[k]);
            if (k == 4) out_ready = 1'b0;  // hold the last result in DONE
            else begin
                @(negedge clk);
            end
        end

        // Backpressure: three cycles in DONE with out_ready low.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp valid %0d", c), out_valid, 1);
            check($sformatf("bp ready %0d", c), req_ready, 0);
            check($sformatf("bp code %0d", c), out_code, 7);
            check($sformatf("bp id %0d", c), out_id, 0);
            check($sformatf("bp err %0d", c), out_err, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        out_ready = 1'b0;
        check("bp released", out_valid, 0);

        // Mid-SCAN reset: requester 2 (ptr is 1) sends 0000001.
        @(negedge clk);
        req_data = '0;
        req_data[2*W +: W] = 7'b0000001;
        req_valid = 4'b0100;
        #1;
        check("midrst grant", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst req_ready", req_ready, 0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        check("midrst no result", bad, 0);

        // ptr must be back at 0: requester 0 beats requester 3.
        req_valid = 4'b1001;
        req_data  = {N{7'b0001111}};
        #1;
        check("post-rst grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("post-rst latency", n, 4);
        check("post-rst code", out_code, 4);
        check("post-rst id", out_id, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_thermo_decode_arbiter
